axis_pkt_rr_arbiter: RTL
========================

AXIS_PKT_RR_ARBITER -- requirements
Module: axis_pkt_rr_arbiter

Interface
REQ-001 Parameter NUM_SRC, 4, number of AXI-ST source ports (2..8).
REQ-002 Parameter DATA_WIDTH, 512, tdata width in bits.
REQ-003 Parameter KEEP_BYTES, DATA_WIDTH/8, tkeep width.
REQ-004 Parameter SEL_WIDTH, $clog2(NUM_SRC), grant index width.
REQ-005 Port clk  in  1  clock; all logic rising-edge.
REQ-006 Port srst  in  1  reset, synchronous, active-high.
REQ-007 Port s_tdata  in  NUM_SRC*DATA_WIDTH  source data; source i in slice i.
REQ-008 Port s_tkeep  in  NUM_SRC*KEEP_BYTES  source byte enables.
REQ-009 Port s_tvalid  in  NUM_SRC  per-source valid.
REQ-010 Port s_tlast  in  NUM_SRC  per-source end of packet.
REQ-011 Port s_tready  out  NUM_SRC  per-source ready.
REQ-012 Port m_tdata  out  DATA_WIDTH  merged data toward the sideband-CRC appender.
REQ-013 Port m_tkeep  out  KEEP_BYTES  merged byte enables.
REQ-014 Port m_tvalid  out  1  merged valid.
REQ-015 Port m_tlast  out  1  merged end of packet.
REQ-016 Port m_tid  out  SEL_WIDTH  index of the source owning the current packet.
REQ-017 Port m_tready  in  1  downstream ready.
REQ-018 Port busy  out  1  high while a packet is granted (state XFER).

Function
REQ-019 FSM states SHALL be IDLE (no grant) and XFER (one source owns the output until its tlast beat transfers).
REQ-020 In IDLE, if any s_tvalid is high, the winner SHALL be registered into grant and the state SHALL move to XFER on the next edge; otherwise stay IDLE.
REQ-021 Round-robin: search SHALL start at last_grant+1, ascending, wrapping modulo NUM_SRC; first requester wins.
REQ-022 In IDLE all s_tready, m_tvalid, m_tlast SHALL be 0; m_tdata, m_tkeep, m_tid SHALL be 0.
REQ-023 In XFER, m_tdata/m_tkeep/m_tvalid/m_tlast SHALL combinationally equal source grant's signals; m_tid SHALL equal grant.
REQ-024 In XFER, s_tready[grant] SHALL equal m_tready; all other s_tready SHALL be 0.
REQ-025 A beat transfers when m_tvalid && m_tready; on a transfer with m_tlast=1, state SHALL return to IDLE and last_grant SHALL load grant.
REQ-026 Arbitration latency SHALL be exactly one bubble cycle (IDLE) between packets; first beat of a granted packet appears the cycle after the request is seen.
REQ-027 Grant SHALL NOT change mid-packet, regardless of other requests or grant-source tvalid deasserting.
REQ-028 A single-beat packet (tvalid and tlast on first beat) SHALL complete in one XFER cycle when m_tready=1.
REQ-029 Requests arriving while in XFER SHALL be held off (tready=0) and SHALL be evaluated in the next IDLE cycle.

Reset
REQ-030 On srst, state SHALL be IDLE, grant 0, last_grant NUM_SRC-1 (so source 0 wins first), busy 0.
REQ-031 srst asserted mid-packet SHALL abort the packet: all outputs per REQ-022 in the cycle after srst is sampled; no partial-packet recovery.

Configuration
REQ-032 Macro AXIS_ARB_STRICT_PRIO_EN: when defined, REQ-021 is replaced by fixed priority, lowest active index wins, last_grant ignored; when undefined, round-robin per REQ-021.

Verification
REQ-033 Reset then s_tvalid=4'b1111, each source 3-beat packets, m_tready=1 -> m_tid sequence 0,1,2,3,0; one idle cycle between packets.
REQ-034 Source 2 mid-packet deasserts tvalid 2 cycles while source 1 requests -> m_tvalid=0 those cycles, grant stays 2, m_tid=2 until tlast.
REQ-035 m_tready toggling 1,0,1,0 during a 4-beat packet from source 3 -> s_tready[3] mirrors m_tready, exactly 4 transfers, data order preserved.
REQ-036 Only source 1 requests, back-to-back single-beat packets -> m_tid=1 every packet, m_tvalid pattern 0,1,0,1.
REQ-037 srst pulsed on beat 2 of a 5-beat packet from source 0 -> next cycle m_tvalid=0, busy=0, all s_tready=0; next grant goes to source 0.
REQ-038 With AXIS_ARB_STRICT_PRIO_EN defined, sources 0 and 3 continuously requesting -> m_tid always 0; without macro -> alternates 0,3.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_pkt_rr_arbiter
//
// Packet-level arbiter that merges NUM_SRC AXI-Stream sources onto one
// output stream feeding the sideband-CRC appender. A source, once granted,
// owns the output until its tlast beat transfers. There is always one idle
// (arbitration) cycle between packets.
//
// Arbitration is round-robin by default: the search starts one past the
// last source to finish a packet. Defining AXIS_ARB_STRICT_PRIO_EN switches
// to fixed priority, where the lowest requesting index always wins.
//
// Ports
//   clk       in   clock, rising edge
//   srst      in   synchronous active-high reset (aborts any packet)
//   s_tdata   in   NUM_SRC*DATA_WIDTH, source i occupies slice i
//   s_tkeep   in   NUM_SRC*KEEP_BYTES, per-source byte enables
//   s_tvalid  in   NUM_SRC, per-source valid
//   s_tlast   in   NUM_SRC, per-source end of packet
//   s_tready  out  NUM_SRC, per-source ready (only the granted source)
//   m_tdata   out  DATA_WIDTH, merged data (zero when idle)
//   m_tkeep   out  KEEP_BYTES, merged byte enables (zero when idle)
//   m_tvalid  out  merged valid
//   m_tlast   out  merged end of packet
//   m_tid     out  SEL_WIDTH, index of the source owning the packet
//   m_tready  in   downstream ready
//   busy      out  high while a packet is granted
// ---------------------------------------------------------------------------
module axis_pkt_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_BYTES = DATA_WIDTH / 8,
    parameter int SEL_WIDTH  = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC*KEEP_BYTES-1:0] s_tkeep,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic [KEEP_BYTES-1:0]         m_tkeep,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic [SEL_WIDTH-1:0]          m_tid,
    input  logic                          m_tready,
    output logic                          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SEL_WIDTH-1:0] grant;
    logic [SEL_WIDTH-1:0] grant_nxt;
    logic [SEL_WIDTH-1:0] last_grant;
    logic [SEL_WIDTH-1:0] last_grant_nxt;
    logic [SEL_WIDTH-1:0] winner;
    logic                 any_req;

    assign any_req = |s_tvalid;

    // Winner selection, evaluated only while IDLE.
`ifdef AXIS_ARB_STRICT_PRIO_EN
    always_comb begin
        winner = '0;
        // Descending scan so the lowest requesting index is written last.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (s_tvalid[i]) begin
                winner = SEL_WIDTH'(i);
            end
        end
    end
`else
    always_comb begin
        logic                 found;
        logic [SEL_WIDTH:0]   sum;
        logic [SEL_WIDTH-1:0] idx;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        // Visit last_grant+1 .. last_grant+NUM_SRC modulo NUM_SRC, so the
        // previous owner is considered last.
        for (int k = 1; k <= NUM_SRC; k++) begin
            sum = {1'b0, last_grant} + (SEL_WIDTH + 1)'(k);
            if (sum >= (SEL_WIDTH + 1)'(NUM_SRC)) begin
                sum = sum - (SEL_WIDTH + 1)'(NUM_SRC);
            end
            idx = sum[SEL_WIDTH-1:0];
            if (!found && s_tvalid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= IDLE;
            grant      <= '0;
            // Pointing at the highest index makes source 0 the first winner.
            last_grant <= SEL_WIDTH'(NUM_SRC - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        s_tready       = '0;
        m_tdata        = '0;
        m_tkeep        = '0;
        m_tvalid       = 1'b0;
        m_tlast        = 1'b0;
        m_tid          = '0;
        busy           = 1'b0;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = winner;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                busy             = 1'b1;
                m_tdata          = s_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
                m_tkeep          = s_tkeep[grant*KEEP_BYTES +: KEEP_BYTES];
                m_tvalid         = s_tvalid[grant];
                m_tlast          = s_tlast[grant];
                m_tid            = grant;
                // Ready follows downstream even while the owner stalls its
                // valid; the grant is held until the tlast beat moves.
                s_tready[grant]  = m_tready;
                if (s_tvalid[grant] && m_tready && s_tlast[grant]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
